// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background SECDED scrubber that walks memory through an external decoder.
// Optional writeback re-read verification is enabled by defining ECC_SCRUB_WB_VERIFY_EN.
module ecc_scrub_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned INTERVAL  = 256,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cnt_clr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [38:0]          mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [38:0]          mem_rdata,
  output logic                 dec_en,
  output logic [31:0]          dec_din,
  output logic [6:0]           dec_ecc_in,
  input  logic [31:0]          dec_dout,
  input  logic [6:0]           dec_ecc_out,
  input  logic                 dec_single,
  input  logic                 dec_double,
  output logic [ERR_CNT_W-1:0] sec_cnt,
  output logic [ERR_CNT_W-1:0] ded_cnt,
  output logic                 ded_irq,
  output logic [ADDR_W-1:0]    ded_addr,
  output logic                 wb_fail,
  output logic                 pass_done,
  output logic                 busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ECC_W  = 7;
  localparam int unsigned CW_W   = DATA_W + ECC_W;
  localparam int unsigned IV_W   = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  localparam logic [IV_W-1:0]   IV_RELOAD = IV_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_WR_REQ,
    S_NEXT
`ifdef ECC_SCRUB_WB_VERIFY_EN
    ,
    S_VR_REQ,
    S_VR_WAIT,
    S_VR_CHECK
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [IV_W-1:0]     iv_q, iv_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW_W-1:0]     rdata_q, rdata_d;
  logic [CW_W-1:0]     wdata_d;
  logic [ADDR_W-1:0]   ded_addr_d;
  logic [ERR_CNT_W-1:0] sec_d, ded_d;
  logic                sec_inc, ded_inc;
  logic                ded_irq_d, pass_done_d;
  logic                req_d, we_d, dec_en_d, busy_d;

  // Saturating counter step; a clear wins over a same-cycle increment.
  function automatic logic [ERR_CNT_W-1:0] cnt_step(input logic [ERR_CNT_W-1:0] cur,
                                                    input logic inc, input logic clr);
    if (clr) return '0;
    if (inc && (cur != '1)) return cur + ERR_CNT_W'(1);
    return cur;
  endfunction

  assign mem_addr   = addr_q;
  assign dec_din    = rdata_q[DATA_W-1:0];
  assign dec_ecc_in = rdata_q[CW_W-1:DATA_W];

`ifdef ECC_SCRUB_WB_VERIFY_EN
  logic wb_fail_q, wb_fail_d;
  assign wb_fail = wb_fail_q;
`else
  assign wb_fail = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    iv_d        = iv_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    wdata_d     = mem_wdata;
    ded_addr_d  = ded_addr;
    sec_inc     = 1'b0;
    ded_inc     = 1'b0;
    ded_irq_d   = 1'b0;
    pass_done_d = 1'b0;
`ifdef ECC_SCRUB_WB_VERIFY_EN
    wb_fail_d   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          iv_d    = IV_RELOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!en)               state_d = S_IDLE;
        else if (iv_q == '0)   state_d = S_RD_REQ;
        else                   iv_d    = iv_q - IV_W'(1);
      end
      S_RD_REQ: begin
        if (mem_gnt) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dec_double) begin
          ded_inc    = 1'b1;
          ded_irq_d  = 1'b1;
          ded_addr_d = addr_q;
          state_d    = S_NEXT;
        end else if (dec_single) begin
          sec_inc = 1'b1;
          wdata_d = {dec_ecc_out, dec_dout};
          state_d = S_WR_REQ;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WR_REQ: begin
`ifdef ECC_SCRUB_WB_VERIFY_EN
        if (mem_gnt) state_d = S_VR_REQ;
`else
        if (mem_gnt) state_d = S_NEXT;
`endif
      end
`ifdef ECC_SCRUB_WB_VERIFY_EN
      S_VR_REQ: begin
        if (mem_gnt) state_d = S_VR_WAIT;
      end
      S_VR_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = S_VR_CHECK;
        end
      end
      S_VR_CHECK: begin
        // A corrected word that still decodes dirty is treated as uncorrectable.
        if (dec_single || dec_double) begin
          wb_fail_d = 1'b1;
          ded_inc   = 1'b1;
        end
        state_d = S_NEXT;
      end
`endif
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d      = '0;
          pass_done_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (en) begin
          iv_d    = IV_RELOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sec_d = cnt_step(sec_cnt, sec_inc, cnt_clr);
    ded_d = cnt_step(ded_cnt, ded_inc, cnt_clr);

    // Bus and decoder controls are registered copies of the upcoming state.
    req_d    = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    we_d     = (state_d == S_WR_REQ);
    dec_en_d = (state_d == S_CHECK);
`ifdef ECC_SCRUB_WB_VERIFY_EN
    req_d    = req_d || (state_d == S_VR_REQ);
    dec_en_d = dec_en_d || (state_d == S_VR_CHECK);
`endif
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      iv_q      <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      mem_wdata <= '0;
      ded_addr  <= '0;
      sec_cnt   <= '0;
      ded_cnt   <= '0;
      ded_irq   <= 1'b0;
      pass_done <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      dec_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      iv_q      <= iv_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      mem_wdata <= wdata_d;
      ded_addr  <= ded_addr_d;
      sec_cnt   <= sec_d;
      ded_cnt   <= ded_d;
      ded_irq   <= ded_irq_d;
      pass_done <= pass_done_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      dec_en    <= dec_en_d;
      busy      <= busy_d;
    end
  end

`ifdef ECC_SCRUB_WB_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wb_fail_q <= 1'b0;
    else     wb_fail_q <= wb_fail_d;
  end
`endif

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background scrubber for a SECDED-protected (39-bit codeword: ECC[38:32], data[31:0]) memory. It walks all addresses and reads each codeword through an external combinational rvecc_decode instance. Single-bit errors are written back corrected; double-bit errors are counted, their address is latched and an interrupt is pulsed. It sits between the memory arbiter port and the decoder.

Parameters:
ADDR_W, 10, memory address width
DEPTH, 1024, number of words scrubbed per pass (2 to 2**ADDR_W)
INTERVAL, 256, idle cycles between scrub reads (>=1)
ERR_CNT_W, 16, width of the saturating error counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
en  in  1  scrubbing enable
cnt_clr  in  1  synchronous clear of sec_cnt/ded_cnt
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  request address
mem_wdata  out  39  corrected codeword {ecc,data}
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  39  read codeword {ecc,data}
dec_en  out  1  decoder enable
dec_din  out  32  decoder data in
dec_ecc_in  out  7  decoder ECC in
dec_dout  in  32  decoder corrected data
dec_ecc_out  in  7  decoder corrected ECC
dec_single  in  1  decoder single_ecc_error
dec_double  in  1  decoder double_ecc_error
sec_cnt  out  ERR_CNT_W  corrected-error count
ded_cnt  out  ERR_CNT_W  uncorrectable-error count
ded_irq  out  1  1-cycle pulse per double error
ded_addr  out  ADDR_W  address of last double error
wb_fail  out  1  1-cycle pulse, writeback verify failed
pass_done  out  1  1-cycle pulse at end of pass
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async): state IDLE, scrub address 0, interval counter 0, all outputs 0.
- FSM states: IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
- IDLE: when en=1, load interval counter with INTERVAL-1 and go to WAIT.
- WAIT: decrement the counter; at 0 go to RD_REQ. If en=0, go to IDLE.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=scrub address. Hold until mem_gnt, then go to RD_WAIT.
- RD_WAIT: on mem_rvalid, register mem_rdata and go to CHECK. rvalid in any other state is ignored.
- dec_din/dec_ecc_in are driven from the registered codeword at all times. dec_en=1 only in CHECK.
- CHECK, branch on decoder flags:
  - dec_double (with or without dec_single): ded_cnt+1, ded_irq pulse, ded_addr<=scrub address, go to NEXT (no write).
  - dec_single only: sec_cnt+1, register {dec_ecc_out,dec_dout}, go to WR_REQ.
  - No flags: go to NEXT.
- WR_REQ: mem_req=1, mem_we=1, mem_addr and mem_wdata held stable until mem_gnt, then go to NEXT.
- NEXT: if address==DEPTH-1, wrap to 0 and pulse pass_done; otherwise address+1. Go to WAIT (reload the counter) if en=1, else IDLE.
- Deasserting en mid-word does not abort. The current word completes and the FSM goes to IDLE at NEXT.
- While mem_req=1, mem_addr, mem_we and mem_wdata must not change until mem_gnt.
- Counters saturate at all-ones. cnt_clr has priority over a same-cycle increment.
- Minimum latency per clean word with immediate gnt and rvalid one cycle later: RD_REQ, RD_WAIT, CHECK, NEXT = 4 cycles.

Optional Feature:
ECC_SCRUB_WB_VERIFY_EN: when defined, WR_REQ goes to VR_REQ/VR_WAIT/VR_CHECK, which re-read the same address. If the decoder flags any error, pulse wb_fail and increment ded_cnt; then go to NEXT. When undefined, WR_REQ goes straight to NEXT and wb_fail is tied 0.

Test Plan:
- Clean 8-word memory, DEPTH=8, INTERVAL=4, en=1 -> 8 reads, 0 writes, one pass_done after address 7, address back to 0, counters 0.
- Flip bit 5 at address 3 -> one write to address 3 with the original codeword, sec_cnt=1. Second pass issues no write.
- Flip bits 0 and 38 at address 5 -> ded_irq one pulse, ded_addr=5, ded_cnt=1, no write. Second pass gives ded_cnt=2.
- Hold mem_gnt=0 for 10 cycles in RD_REQ -> mem_req=1 and mem_addr stable throughout, FSM does not advance.
- ERR_CNT_W=2, 5 single-error words -> sec_cnt=3 (saturated). cnt_clr -> 0.
- Drop en in RD_WAIT -> word completes, then IDLE, busy=0, address+1. Assert rst in WR_REQ -> all outputs 0 immediately.
